// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bus: EX-side capture fields and MEM-side registered fields.
// master drives the EX-side inputs and observes outputs; slave is the register itself.
interface ex_mem_reg_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 16,
    parameter int RSEL_W = 3
);
    logic              stall;
    logic              flush;
    logic              validIn;
    logic [CTRL_W-1:0] CtrlIn;
    logic [DATA_W-1:0] PCAdd2In;
    logic [DATA_W-1:0] ALUResultIn;
    logic [DATA_W-1:0] StoreDataIn;
    logic [RSEL_W-1:0] WriteRegSelIn;
    logic              errIn;

    logic              validOut;
    logic [CTRL_W-1:0] CtrlOut;
    logic [DATA_W-1:0] PCAdd2Out;
    logic [DATA_W-1:0] ALUResultOut;
    logic [DATA_W-1:0] StoreDataOut;
    logic [RSEL_W-1:0] WriteRegSelOut;
    logic              errOut;
    logic              errSticky;

    modport master (
        output stall, flush, validIn, CtrlIn, PCAdd2In,
        output ALUResultIn, StoreDataIn, WriteRegSelIn, errIn,
        input  validOut, CtrlOut, PCAdd2Out, ALUResultOut,
        input  StoreDataOut, WriteRegSelOut, errOut, errSticky
    );

    modport slave (
        input  stall, flush, validIn, CtrlIn, PCAdd2In,
        input  ALUResultIn, StoreDataIn, WriteRegSelIn, errIn,
        output validOut, CtrlOut, PCAdd2Out, ALUResultOut,
        output StoreDataOut, WriteRegSelOut, errOut, errSticky
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall (hold), flush (bubble), valid bit and error capture.
// Ports: clk, rst (async, active-high), bus (ex_mem_reg_if.slave: *In fields in, *Out fields
// out, errSticky out). Optional EX_MEM_PERF_CNT_EN adds stallCnt/flushCnt saturating counters.
module ex_mem_reg #(
    parameter int                 DATA_W      = 16,
    parameter int                 CTRL_W      = 16,
    parameter int                 RSEL_W      = 3,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0
) (
    input  logic        clk,
    input  logic        rst,
    ex_mem_reg_if.slave bus
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [15:0] stallCnt,
    output logic [15:0] flushCnt
`endif
);

    logic capErr;

    // an error only counts when it rides on a real instruction being loaded
    assign capErr = bus.validIn & bus.errIn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.validOut       <= 1'b0;
            bus.CtrlOut        <= BUBBLE_CTRL;
            bus.PCAdd2Out      <= {DATA_W{1'b0}};
            bus.ALUResultOut   <= {DATA_W{1'b0}};
            bus.StoreDataOut   <= {DATA_W{1'b0}};
            bus.WriteRegSelOut <= {RSEL_W{1'b0}};
            bus.errOut         <= 1'b0;
            bus.errSticky      <= 1'b0;
        end else if (bus.flush) begin
            bus.validOut       <= 1'b0;
            bus.CtrlOut        <= BUBBLE_CTRL;
            bus.PCAdd2Out      <= {DATA_W{1'b0}};
            bus.ALUResultOut   <= {DATA_W{1'b0}};
            bus.StoreDataOut   <= {DATA_W{1'b0}};
            bus.WriteRegSelOut <= {RSEL_W{1'b0}};
            bus.errOut         <= 1'b0;
        end else if (!bus.stall) begin
            bus.validOut       <= bus.validIn;
            // a bubble must never carry RegWrite/MemWrite downstream
            bus.CtrlOut        <= bus.validIn ? bus.CtrlIn : BUBBLE_CTRL;
            bus.PCAdd2Out      <= bus.PCAdd2In;
            bus.ALUResultOut   <= bus.ALUResultIn;
            bus.StoreDataOut   <= bus.StoreDataIn;
            bus.WriteRegSelOut <= bus.WriteRegSelIn;
            bus.errOut         <= capErr;
            if (capErr) begin
                bus.errSticky <= 1'b1;
            end
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= 16'h0000;
            flushCnt <= 16'h0000;
        end else begin
            if (bus.flush && flushCnt != 16'hFFFF) begin
                flushCnt <= flushCnt + 16'h0001;
            end
            // a flush overrides a stall, so it is not counted as a stall
            if (bus.stall && !bus.flush && stallCnt != 16'hFFFF) begin
                stallCnt <= stallCnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: vector table plus reset and counter sequences.
// Inputs driven on the falling edge; outputs sampled 1 time unit after the rising edge.
module tb_ex_mem_reg;

    logic clk;
    logic rst;

    ex_mem_reg_if #(.DATA_W(16), .CTRL_W(16), .RSEL_W(3)) bus ();

`ifdef EX_MEM_PERF_CNT_EN
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;
`endif

    ex_mem_reg #(
        .DATA_W(16), .CTRL_W(16), .RSEL_W(3), .BUBBLE_CTRL(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .stallCnt(stallCnt),
        .flushCnt(flushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        vIn;
        logic [15:0] ctrl;
        logic [15:0] pc;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [2:0]  wsel;
        logic        err;
        logic        eV;
        logic [15:0] eCtrl;
        logic [15:0] ePc;
        logic [15:0] eAlu;
        logic [15:0] eSd;
        logic [2:0]  eWsel;
        logic        eErr;
        logic        eSticky;
    } vec_t;

    vec_t vecs[$];
    int   passCnt = 0;
    int   totalCnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkOut(input string tag, input logic v, input logic [15:0] c,
                          input logic [15:0] p, input logic [15:0] a, input logic [15:0] s,
                          input logic [2:0] w, input logic e, input logic st);
        chk({tag, ".validOut"}, 32'(bus.validOut), 32'(v));
        chk({tag, ".CtrlOut"}, 32'(bus.CtrlOut), 32'(c));
        chk({tag, ".PCAdd2Out"}, 32'(bus.PCAdd2Out), 32'(p));
        chk({tag, ".ALUResultOut"}, 32'(bus.ALUResultOut), 32'(a));
        chk({tag, ".StoreDataOut"}, 32'(bus.StoreDataOut), 32'(s));
        chk({tag, ".WriteRegSelOut"}, 32'(bus.WriteRegSelOut), 32'(w));
        chk({tag, ".errOut"}, 32'(bus.errOut), 32'(e));
        chk({tag, ".errSticky"}, 32'(bus.errSticky), 32'(st));
    endtask

    task automatic drive(input logic st, input logic fl, input logic v,
                         input logic [15:0] c, input logic [15:0] p, input logic [15:0] a,
                         input logic [15:0] s, input logic [2:0] w, input logic e);
        bus.stall         = st;
        bus.flush         = fl;
        bus.validIn       = v;
        bus.CtrlIn        = c;
        bus.PCAdd2In      = p;
        bus.ALUResultIn   = a;
        bus.StoreDataIn   = s;
        bus.WriteRegSelIn = w;
        bus.errIn         = e;
    endtask

    function automatic vec_t mk(
        input logic st, input logic fl, input logic v, input logic [15:0] c,
        input logic [15:0] p, input logic [15:0] a, input logic [15:0] s,
        input logic [2:0] w, input logic e,
        input logic ev, input logic [15:0] ec, input logic [15:0] ep,
        input logic [15:0] ea, input logic [15:0] es, input logic [2:0] ew,
        input logic ee, input logic est);
        vec_t r;
        r.stall = st; r.flush = fl; r.vIn = v; r.ctrl = c; r.pc = p;
        r.alu = a; r.sd = s; r.wsel = w; r.err = e;
        r.eV = ev; r.eCtrl = ec; r.ePc = ep; r.eAlu = ea; r.eSd = es;
        r.eWsel = ew; r.eErr = ee; r.eSticky = est;
        return r;
    endfunction

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0);

        // three plain loads
        vecs.push_back(mk(0,0,1,16'h0A5C,16'h0010,16'h0001,16'h1111,3'd3,0,
                          1,16'h0A5C,16'h0010,16'h0001,16'h1111,3'd3,0,0));
        vecs.push_back(mk(0,0,1,16'h0A5C,16'h0012,16'h0002,16'h2222,3'd4,0,
                          1,16'h0A5C,16'h0012,16'h0002,16'h2222,3'd4,0,0));
        vecs.push_back(mk(0,0,1,16'h0A5C,16'h0014,16'h0003,16'h3333,3'd5,0,
                          1,16'h0A5C,16'h0014,16'h0003,16'h3333,3'd5,0,0));
        // load PC 0x0040 then stall four cycles with changing inputs
        vecs.push_back(mk(0,0,1,16'h1234,16'h0040,16'h0040,16'h0040,3'd6,0,
                          1,16'h1234,16'h0040,16'h0040,16'h0040,3'd6,0,0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1,0,1,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,3'd7,1,
                              1,16'h1234,16'h0040,16'h0040,16'h0040,3'd6,0,0));
        end
        vecs.push_back(mk(0,0,1,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,3'd7,0,
                          1,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,3'd7,0,0));
        // flush wins over stall
        vecs.push_back(mk(1,1,1,16'h00FF,16'h0AAA,16'h0BBB,16'h0CCC,3'd5,1,
                          0,16'h0000,16'h0000,16'h0000,16'h0000,3'd0,0,0));
        // bubble with errIn: ctrl forced to bubble, data loads, error ignored
        vecs.push_back(mk(0,0,0,16'h00FF,16'h0022,16'h0033,16'h0044,3'd2,1,
                          0,16'h0000,16'h0022,16'h0033,16'h0044,3'd2,0,0));
        // valid error
        vecs.push_back(mk(0,0,1,16'h0101,16'h0050,16'h0060,16'h0070,3'd1,1,
                          1,16'h0101,16'h0050,16'h0060,16'h0070,3'd1,1,1));
        // flush clears errOut but not errSticky
        vecs.push_back(mk(0,1,1,16'h0303,16'h0001,16'h0002,16'h0003,3'd4,0,
                          0,16'h0000,16'h0000,16'h0000,16'h0000,3'd0,0,1));
        vecs.push_back(mk(1,0,1,16'h0404,16'h0005,16'h0006,16'h0007,3'd3,1,
                          0,16'h0000,16'h0000,16'h0000,16'h0000,3'd0,0,1));
        vecs.push_back(mk(0,0,1,16'h0202,16'h0100,16'h0200,16'h0300,3'd6,0,
                          1,16'h0202,16'h0100,16'h0200,16'h0300,3'd6,0,1));

        // reset state
        #2 rst = 1'b1;
        #1 chkOut("reset", 0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].vIn, vecs[i].ctrl, vecs[i].pc,
                  vecs[i].alu, vecs[i].sd, vecs[i].wsel, vecs[i].err);
            @(posedge clk);
            #1;
            chkOut($sformatf("vec%0d", i), vecs[i].eV, vecs[i].eCtrl, vecs[i].ePc,
                   vecs[i].eAlu, vecs[i].eSd, vecs[i].eWsel, vecs[i].eErr, vecs[i].eSticky);
            @(negedge clk);
        end

        // reset mid-operation, asserted between edges
        drive(0, 0, 1, 16'h0A5C, 16'h0008, 16'h1234, 16'h5678, 3'd5, 0);
        @(posedge clk);
        #1 chkOut("preRst", 1, 16'h0A5C, 16'h0008, 16'h1234, 16'h5678, 3'd5, 0, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chkOut("asyncRst", 0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0);
        @(posedge clk);
        #1 chkOut("rstHeld", 0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chkOut("postRst", 1, 16'h0A5C, 16'h0008, 16'h1234, 16'h5678, 3'd5, 0, 0);
        @(negedge clk);

`ifdef EX_MEM_PERF_CNT_EN
        #1 rst = 1'b1;
        #1 chk("cnt.rstStall", 32'(stallCnt), 32'h0);
        chk("cnt.rstFlush", 32'(flushCnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 1, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 0);
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        @(negedge clk);
        bus.stall = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        @(negedge clk);
        chk("cnt.stall5", 32'(stallCnt), 32'd5);
        chk("cnt.flush2", 32'(flushCnt), 32'd2);
        bus.stall = 1'b1;
        repeat (65529) @(negedge clk);
        chk("cnt.stallFFFE", 32'(stallCnt), 32'hFFFE);
        repeat (3) @(negedge clk);
        bus.stall = 1'b0;
        chk("cnt.stallSat", 32'(stallCnt), 32'hFFFF);
        chk("cnt.flushHold", 32'(flushCnt), 32'd2);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
